data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data word on the CPU port and the memory port.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter SETS, default 16, number of direct-mapped lines; a power of two, minimum 2.
REQ-004 Parameter WORDS_PER_LINE, default 4, words per line; a power of two, minimum 2.
REQ-005 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-low.
REQ-007 req_i  input  1  memory-stage access valid (load or store).
REQ-008 we_i  input  1  1 = store, 0 = load; qualified by req_i.
REQ-009 addr_i  input  ADDR_WIDTH  byte address; bits [1:0] ignored (word access only).
REQ-010 wdata_i  input  DATA_WIDTH  store data.
REQ-011 rdata_o  output  DATA_WIDTH  load data; valid when req_i=1, we_i=0 and stall_o=0.
REQ-012 stall_o  output  1  to hazard unit; 1 = hold the pipeline, CPU request held stable.
REQ-013 mem_req_o  output  1  backing-memory request valid.
REQ-014 mem_we_o  output  1  backing-memory write strobe.
REQ-015 mem_addr_o  output  ADDR_WIDTH  word-aligned backing-memory address.
REQ-016 mem_wdata_o  output  DATA_WIDTH  backing-memory write data.
REQ-017 mem_rdata_i  input  DATA_WIDTH  backing-memory read data; valid with mem_ready_i.
REQ-018 mem_ready_i  input  1  backing memory accepts/completes the current beat.

Function
REQ-019 Address split: offset = addr_i[1+log2(WORDS_PER_LINE):2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-020 Per line: valid bit, tag, WORDS_PER_LINE data words; policy direct-mapped, write-through, no-write-allocate.
REQ-021 FSM states: IDLE, REFILL, WRITE.
REQ-022 Hit = req_i & valid[index] & (tag[index] == tag).
REQ-023 IDLE, load hit: rdata_o = selected word combinationally, stall_o=0, no memory request, zero-cycle latency.
REQ-024 IDLE, load miss: stall_o=1 in the same cycle; next state REFILL; beat counter cleared; valid[index] cleared.
REQ-025 REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o = {tag,index,beat,2'b00}; each cycle with mem_ready_i=1 writes mem_rdata_i into word[beat] and increments the beat.
REQ-026 On the final beat's handshake, the block sets valid and writes the tag, then returns to IDLE; stall_o stays 1 through that cycle, and the held load hits the following cycle.
REQ-027 IDLE, store (hit or miss): stall_o=1 in the same cycle; next state WRITE.
REQ-028 WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o = {addr_i[ADDR_WIDTH-1:2],2'b00}, mem_wdata_o=wdata_i; on mem_ready_i=1 the beat completes.
REQ-029 In the WRITE completion cycle, stall_o=0 combinationally, and the FSM returns to IDLE, so the pipeline advances at that edge and the store is not reissued.
REQ-030 On a store hit, the cached word is updated at the WRITE completion edge; on a store miss, the cache array is unchanged.
REQ-031 Memory handshake: mem_addr_o, mem_we_o and mem_wdata_o hold stable while mem_req_o=1 and mem_ready_i=0; mem_ready_i is ignored when mem_req_o=0.
REQ-032 In IDLE, mem_req_o=0 and stall_o=0 unless REQ-024/REQ-027 apply.
REQ-033 Once started, a refill runs to completion even if req_i drops; the line is never partially valid.
REQ-034 A beat counter wrap from WORDS_PER_LINE-1 to 0 occurs only at refill end.
REQ-035 A load to the index being refilled is impossible because the pipeline is stalled; no forwarding from in-flight beats.

Reset
REQ-036 While rst_i=0: state=IDLE, all valid bits=0, beat counter=0, stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; the data and tag arrays are not reset.
REQ-037 Reset asserted mid-REFILL or mid-WRITE aborts immediately; after release the aborted line is invalid and no memory request is pending.
REQ-038 rdata_o has no reset requirement; it is don't-care while stall_o=1 or req_i=0.

Verification
REQ-039 Cold load 0x0000_0040; memory returns 0xA0,0xA1,0xA2,0xA3 with mem_ready_i=1 each cycle -> 4 beats at 0x40,0x44,0x48,0x4C; stall_o high 5 cycles total; then rdata_o=0xA0 with stall_o=0.
REQ-040 After REQ-039, load 0x48 -> rdata_o=0xA2, stall_o=0 the same cycle, mem_req_o never asserts.
REQ-041 Store 0xDEAD_BEEF to 0x44 (hit), mem_ready_i delayed 3 cycles -> mem_req_o/mem_we_o held with addr 0x44 for 4 cycles; stall_o drops in the ready cycle; a following load of 0x44 returns 0xDEADBEEF with no refill.
REQ-042 Store to 0x0000_1044 (same index, different tag) -> one memory write; a subsequent load of 0x44 still hits with its old value.
REQ-043 Load 0x0000_1040 evicts the line (conflict) -> refill of 0x1040..0x104C, then a load of 0x40 misses and refills again.
REQ-044 rst_i driven low after beat 2 of a refill -> mem_req_o=0 asynchronously; after release, a load of the same address performs a full 4-beat refill.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for an in-order pipeline.
// Load hits return data combinationally; misses refill a whole line; stores write through one beat.
module data_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int LOC_W = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        beat_q, beat_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]        ref_tag_q, ref_tag_d;
    logic [IDX_W-1:0]        ref_idx_q, ref_idx_d;

    logic [DATA_WIDTH-1:0]   data_q [SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]        tag_q  [SETS];

    logic [OFF_W-1:0]        off_s;
    logic [IDX_W-1:0]        idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic                    hit_s;
    logic                    stall_s;
    logic                    data_we_s;
    logic [LOC_W-1:0]        data_waddr_s;
    logic [DATA_WIDTH-1:0]   data_wval_s;
    logic                    tag_we_s;
    logic                    unused_addr_s;

    assign off_s         = addr_i[2 +: OFF_W];
    assign idx_s         = addr_i[2 + OFF_W +: IDX_W];
    assign tag_s         = addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign hit_s         = req_i & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    assign rdata_o       = data_q[{idx_s, off_s}];
    assign unused_addr_s = ^addr_i[1:0];

    // Stall is forced low while reset is asserted, even with a request pending.
    assign stall_o = stall_s & rst_i;

    // Next-state, memory-port and array-write decode for the controller.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        ref_tag_d    = ref_tag_q;
        ref_idx_d    = ref_idx_q;
        stall_s      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = {ADDR_WIDTH{1'b0}};
        mem_wdata_o  = {DATA_WIDTH{1'b0}};
        data_we_s    = 1'b0;
        data_waddr_s = {idx_s, off_s};
        data_wval_s  = wdata_i;
        tag_we_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i && we_i) begin
                    stall_s = 1'b1;
                    state_d = ST_WRITE;
                end else if (req_i && !hit_s) begin
                    // Drop the line now so a reset mid-refill can never leave it half-valid.
                    stall_s          = 1'b1;
                    state_d          = ST_REFILL;
                    beat_d           = {OFF_W{1'b0}};
                    valid_d[idx_s]   = 1'b0;
                    ref_tag_d        = tag_s;
                    ref_idx_d        = idx_s;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_REFILL: begin
                stall_s    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {ref_tag_q, ref_idx_q, beat_q, 2'b00};
                if (mem_ready_i) begin
                    data_we_s    = 1'b1;
                    data_waddr_s = {ref_idx_q, beat_q};
                    data_wval_s  = mem_rdata_i;
                    if (beat_q == LAST_BEAT) begin
                        beat_d             = {OFF_W{1'b0}};
                        valid_d[ref_idx_q] = 1'b1;
                        tag_we_s           = 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_WRITE: begin
                stall_s     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_o = wdata_i;
                if (mem_ready_i) begin
                    // Release the pipeline in the completion cycle so the store is not replayed.
                    stall_s   = 1'b0;
                    state_d   = ST_IDLE;
                    data_we_s = hit_s;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, beat counter, valid bits and latched refill line address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            beat_q    <= {OFF_W{1'b0}};
            valid_q   <= {SETS{1'b0}};
            ref_tag_q <= {TAG_W{1'b0}};
            ref_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            valid_q   <= valid_d;
            ref_tag_q <= ref_tag_d;
            ref_idx_q <= ref_idx_d;
        end
    end

    // Data and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (data_we_s) begin
            data_q[data_waddr_s] <= data_wval_s;
        end
        if (tag_we_s) begin
            tag_q[ref_idx_q] <= ref_tag_q;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized traffic
// checked against a line-presence / flat-memory reference model.
module tb_data_cache;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SETS = 16;
    localparam int WPL  = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ready_i;

    always #5 clk_i = ~clk_i;

    data_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(SETS), .WORDS_PER_LINE(WPL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] bmem [int unsigned];
    logic [31:0] rmem [int unsigned];
    bit          ref_valid [SETS];
    int unsigned ref_tag   [SETS];
    int          fixed_delay = 0;
    bit          rand_delay  = 1'b0;
    int          wait_cnt    = 0;
    int          cur_delay   = 0;

    function automatic logic [31:0] init_word(int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] bmem_rd(int unsigned w);
        return bmem.exists(w) ? bmem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] rmem_rd(int unsigned w);
        return rmem.exists(w) ? rmem[w] : init_word(w);
    endfunction

    function automatic int unsigned line_idx(logic [31:0] a);
        return (a / LINE_BYTES) % SETS;
    endfunction

    function automatic int unsigned line_tag(logic [31:0] a);
        return a / (LINE_BYTES * SETS);
    endfunction

    function automatic bit present(logic [31:0] a);
        return ref_valid[line_idx(a)] && (ref_tag[line_idx(a)] == line_tag(a));
    endfunction

    function automatic void ref_fill(logic [31:0] a);
        ref_valid[line_idx(a)] = 1'b1;
        ref_tag[line_idx(a)]   = line_tag(a);
    endfunction

    // Backing memory: drive ready/read data a little after each rising edge.
    always @(posedge clk_i) begin
        #2;
        if (mem_req_o === 1'b1) begin
            mem_ready_i = (wait_cnt >= cur_delay);
            mem_rdata_i = bmem_rd(mem_addr_o >> 2);
        end else begin
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
        end
    end

    // Backing memory: log each handshake that will complete at the next edge.
    always @(negedge clk_i) begin
        if (mem_req_o === 1'b1 && mem_ready_i === 1'b1) begin
            txq.push_back('{mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : mem_rdata_i)});
            if (mem_we_o) bmem[mem_addr_o >> 2] = mem_wdata_o;
            wait_cnt  = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end else if (mem_req_o === 1'b1) begin
            wait_cnt++;
        end else begin
            wait_cnt  = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end
    end

    task automatic idle();
        req_i = 1'b0;
        we_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // Present one CPU access (called at posedge+1) and hold it until the cache releases it.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output logic [31:0] rd);
        bit done = 1'b0;
        stalls = 0;
        rd     = '0;
        txq.delete();
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_i);
            if (stall_o === 1'b0) begin
                rd   = rdata_o;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_timeout addr=%h got stall_cycles=%0d want release within 200", a, stalls);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_refill(input string name, input logic [31:0] a);
        logic [31:0] base = a - (a % LINE_BYTES);
        checks++;
        if (txq.size() != WPL) begin
            failures++;
            $display("FAIL %s_beats got=%0d want=%0d", name, txq.size(), WPL);
        end else begin
            for (int k = 0; k < WPL; k++) begin
                checks++;
                if (txq[k].we !== 1'b0 || txq[k].addr !== base + 32'(4 * k)) begin
                    failures++;
                    $display("FAIL %s_beat%0d got we=%b addr=%h want we=0 addr=%h",
                             name, k, txq[k].we, txq[k].addr, base + 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40; wdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got stall=%b mem_req=%b mem_we=%b want 0/0/0", stall_o, mem_req_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", mem_addr_o, mem_wdata_o);
        end
        rst_i = 1'b1; req_i = 1'b0;
        for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_cold_refill();
        int st; logic [31:0] rd;
        do_access(1'b0, 32'h40, 32'h0, st, rd);
        checks++;
        if (st != 5) begin failures++; $display("FAIL cold_stall got=%0d want=5", st); end
        checks++;
        if (rd !== 32'hA0) begin failures++; $display("FAIL cold_rdata got=%h want=000000a0", rd); end
        check_refill("cold", 32'h40);
        ref_fill(32'h40);
        do_access(1'b0, 32'h48, 32'h0, st, rd);
        checks++;
        if (st != 0 || rd !== 32'hA2 || txq.size() != 0) begin
            failures++;
            $display("FAIL hit_0x48 got stall=%0d rdata=%h beats=%0d want 0/000000a2/0", st, rd, txq.size());
        end
        idle();
    endtask

    task automatic test_store_hit_delayed();
        int st = 0; int rq = 0; bit done = 1'b0; logic [31:0] rd;
        fixed_delay = 3;
        txq.delete();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h44; wdata_i = 32'hDEAD_BEEF;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1 && mem_we_o === 1'b1 && mem_addr_o === 32'h44 &&
                mem_wdata_o === 32'hDEAD_BEEF) rq++;
            if (stall_o === 1'b0) done = 1'b1;
            else st++;
        end
        @(posedge clk_i);
        #1;
        fixed_delay = 0;
        rmem[32'h44 >> 2] = 32'hDEAD_BEEF;
        checks++;
        if (!done || st != 4) begin failures++; $display("FAIL store_delay_stall got=%0d want=4", st); end
        checks++;
        if (rq != 4) begin failures++; $display("FAIL store_delay_req_cycles got=%0d want=4", rq); end
        checks++;
        if (txq.size() != 1 || txq[0] !== txn_t'{1'b1, 32'h44, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL store_delay_txn got count=%0d want one write 44/deadbeef", txq.size());
        end
        do_access(1'b0, 32'h44, 32'h0, st, rd);
        checks++;
        if (st != 0 || rd !== 32'hDEAD_BEEF || txq.size() != 0) begin
            failures++;
            $display("FAIL store_hit_readback got stall=%0d rdata=%h beats=%0d want 0/deadbeef/0", st, rd, txq.size());
        end
        idle();
    endtask

    task automatic test_store_miss();
        int st; logic [31:0] rd;
        do_access(1'b1, 32'h1044, 32'hCAFE_F00D, st, rd);
        rmem[32'h1044 >> 2] = 32'hCAFE_F00D;
        checks++;
        if (st != 1 || txq.size() != 1 || txq[0] !== txn_t'{1'b1, 32'h1044, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL store_miss got stall=%0d writes=%0d want 1/1 at 1044", st, txq.size());
        end
        do_access(1'b0, 32'h44, 32'h0, st, rd);
        checks++;
        if (st != 0 || rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_miss_untouched got stall=%0d rdata=%h want 0/deadbeef", st, rd);
        end
        idle();
    endtask

    task automatic test_conflict();
        int st; logic [31:0] rd;
        do_access(1'b0, 32'h1040, 32'h0, st, rd);
        checks++;
        if (st != 5 || rd !== rmem_rd(32'h1040 >> 2)) begin
            failures++;
            $display("FAIL conflict_load got stall=%0d rdata=%h want 5/%h", st, rd, rmem_rd(32'h1040 >> 2));
        end
        check_refill("conflict", 32'h1040);
        ref_fill(32'h1040);
        do_access(1'b0, 32'h40, 32'h0, st, rd);
        checks++;
        if (st != 5 || rd !== 32'hA0) begin
            failures++;
            $display("FAIL evicted_reload got stall=%0d rdata=%h want 5/000000a0", st, rd);
        end
        check_refill("evicted", 32'h40);
        ref_fill(32'h40);
        idle();
    endtask

    task automatic test_refill_req_drop();
        int st; logic [31:0] rd;
        txq.delete();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h2300;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        req_i = 1'b0; addr_i = 32'h0;
        repeat (WPL + 2) @(posedge clk_i);
        #1;
        check_refill("req_drop", 32'h2300);
        ref_fill(32'h2300);
        do_access(1'b0, 32'h2308, 32'h0, st, rd);
        checks++;
        if (st != 0 || rd !== rmem_rd(32'h2308 >> 2)) begin
            failures++;
            $display("FAIL req_drop_hit got stall=%0d rdata=%h want 0/%h", st, rd, rmem_rd(32'h2308 >> 2));
        end
        idle();
    endtask

    task automatic test_reset_mid_refill();
        int st; logic [31:0] rd;
        txq.delete();
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h80;
        for (int c = 0; c < 50 && txq.size() < 2; c++) begin
            @(negedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got mem_req=%b stall=%b want 0/0", mem_req_o, stall_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1; req_i = 1'b0;
        for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
        @(posedge clk_i);
        #1;
        do_access(1'b0, 32'h80, 32'h0, st, rd);
        checks++;
        if (st != 5 || rd !== rmem_rd(32'h80 >> 2)) begin
            failures++;
            $display("FAIL reset_refill got stall=%0d rdata=%h want 5/%h", st, rd, rmem_rd(32'h80 >> 2));
        end
        check_refill("post_reset", 32'h80);
        ref_fill(32'h80);
        do_access(1'b0, 32'h40, 32'h0, st, rd);
        checks++;
        if (st != 5) begin failures++; $display("FAIL reset_clears_valid got stall=%0d want 5", st); end
        ref_fill(32'h40);
        idle();
    endtask

    task automatic test_random();
        int st; logic [31:0] rd; logic [31:0] a; logic [31:0] d; logic w; bit hit;
        rand_delay = 1'b1;
        for (int i = 0; i < 150; i++) begin
            w   = ($urandom_range(0, 9) < 3);
            a   = 32'($urandom_range(0, 2) * LINE_BYTES * SETS + $urandom_range(0, SETS - 1) * LINE_BYTES
                      + $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3));
            d   = $urandom;
            hit = present(a);
            do_access(w, a, d, st, rd);
            if (w) begin
                checks++;
                if (txq.size() != 1 || txq[0] !== txn_t'{1'b1, a & 32'hFFFF_FFFC, d} || st < 1) begin
                    failures++;
                    $display("FAIL rnd_store addr=%h got writes=%0d stall=%0d want one write of %h", a, txq.size(), st, d);
                end
                rmem[a >> 2] = d;
            end else begin
                checks++;
                if (rd !== rmem_rd(a >> 2)) begin
                    failures++;
                    $display("FAIL rnd_load_data addr=%h got=%h want=%h", a, rd, rmem_rd(a >> 2));
                end
                if (hit) begin
                    checks++;
                    if (st != 0 || txq.size() != 0) begin
                        failures++;
                        $display("FAIL rnd_hit addr=%h got stall=%0d beats=%0d want 0/0", a, st, txq.size());
                    end
                end else begin
                    checks++;
                    if (st < 1 + WPL) begin
                        failures++;
                        $display("FAIL rnd_miss_stall addr=%h got=%0d want>=%0d", a, st, 1 + WPL);
                    end
                    check_refill("rnd_miss", a);
                    ref_fill(a);
                end
            end
            if ($urandom_range(0, 1) == 1) idle();
        end
        rand_delay = 1'b0;
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; rst_i = 1'b0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        for (int k = 0; k < WPL; k++) begin
            bmem[16 + k] = 32'hA0 + 32'(k);
            rmem[16 + k] = 32'hA0 + 32'(k);
        end
        test_reset();
        test_cold_refill();
        test_store_hit_delayed();
        test_store_miss();
        test_conflict();
        test_refill_req_drop();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
